cic_decimator: RTL

//  Parametrised N-stage CIC (Hogenauer) decimator for a 1-bit sigma-delta bitstream, run-time decimation ratio R = 2^dec_log2.

---
 rtl/cic_decimator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cic_decimator.sv
// N-stage CIC decimator for a 1-bit bitstream with run-time ratio 2^dec_log2 and gain normalisation.
// Latency: z lands N_STAGES+1 clks after the frame-end tick; no backpressure, z holds between z_valid strobes.
module cic_decimator #(
  parameter int  N_STAGES  = 3,
  parameter int  LOG2_RMAX = 6,
  parameter int  OUT_W     = 16,
  localparam int ACC_W     = N_STAGES * LOG2_RMAX + 1,
  localparam int DR_W      = $clog2(LOG2_RMAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             clr,
  input  logic [DR_W-1:0]  dec_log2,
  output logic [OUT_W-1:0] z,
  output logic             z_valid
);

  localparam int SUP_W = $clog2(N_STAGES + 1);
  localparam int SH_W  = $clog2(N_STAGES * LOG2_RMAX + 1);
  localparam int CNT_W = LOG2_RMAX;
  localparam logic [DR_W-1:0] RMAX_D = DR_W'(LOG2_RMAX);

  logic [DR_W-1:0]  dec_c;
  logic [DR_W-1:0]  r_act;
  logic [DR_W-1:0]  r_eff;
  logic             ld_pend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic             tick;
  logic [SUP_W-1:0] supp;

  logic [ACC_W-1:0] integ [N_STAGES];
  logic [ACC_W-1:0] dly   [N_STAGES];
  logic [ACC_W-1:0] cdat  [N_STAGES+1];
  logic             cvld  [N_STAGES+1];
  logic             cemit [N_STAGES+1];
  logic [DR_W-1:0]  cr    [N_STAGES+1];

  logic [SH_W-1:0]  sh;
  logic [ACC_W-1:0] scaled;
  logic [OUT_W-1:0] z_nxt;

  always_comb begin
    if (dec_log2 == '0)         dec_c = DR_W'(1);
    else if (dec_log2 > RMAX_D) dec_c = RMAX_D;
    else                        dec_c = dec_log2;
  end

  // An async reset cannot load a port value, so the first clock after release picks up the ratio.
  assign r_eff    = ld_pend ? dec_c : r_act;
  assign cnt_last = {CNT_W{1'b1}} >> (RMAX_D - r_eff);
  assign tick     = en & (cnt == cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      r_act   <= RMAX_D;
      ld_pend <= 1'b1;
      supp    <= SUP_W'(N_STAGES);
    end else if (clr) begin
      cnt     <= '0;
      r_act   <= dec_c;
      ld_pend <= 1'b0;
      supp    <= SUP_W'(N_STAGES);
    end else begin
      ld_pend <= 1'b0;
      if (ld_pend) r_act <= dec_c;
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        r_act <= dec_c;
        if (dec_c != r_eff)   supp <= SUP_W'(N_STAGES);
        else if (supp != '0) supp <= supp - 1'b1;
      end
    end
  end

  // Integrators wrap freely; the comb differences cancel the overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else if (en) begin
      integ[0] <= integ[0] + ACC_W'(x);
      for (int k = 1; k < N_STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= N_STAGES; k++) begin
        cdat[k] <= '0; cvld[k] <= 1'b0; cemit[k] <= 1'b0; cr[k] <= '0;
      end
      for (int k = 0; k < N_STAGES; k++) dly[k] <= '0;
    end else if (clr) begin
      for (int k = 0; k <= N_STAGES; k++) begin
        cdat[k] <= '0; cvld[k] <= 1'b0; cemit[k] <= 1'b0; cr[k] <= '0;
      end
      for (int k = 0; k < N_STAGES; k++) dly[k] <= '0;
    end else begin
      cvld[0]  <= tick;
      cemit[0] <= tick & (supp == '0);
      if (tick) begin
        cdat[0] <= integ[N_STAGES-1];
        cr[0]   <= r_eff;
      end
      for (int k = 1; k <= N_STAGES; k++) begin
        cvld[k]  <= cvld[k-1];
        cemit[k] <= cemit[k-1];
        if (cvld[k-1]) begin
          cdat[k]  <= cdat[k-1] - dly[k-1];
          dly[k-1] <= cdat[k-1];
          cr[k]    <= cr[k-1];
        end
      end
    end
  end

  // Shift so that full scale lands on the ACC_W MSB regardless of the frame's ratio.
  always_comb begin
    sh     = SH_W'(N_STAGES * (LOG2_RMAX - int'(cr[N_STAGES])));
    scaled = cdat[N_STAGES] << sh;
  end

  if (ACC_W >= OUT_W) begin : g_trunc
    assign z_nxt = OUT_W'(scaled >> (ACC_W - OUT_W));
  end else begin : g_pad
    assign z_nxt = {scaled, {(OUT_W - ACC_W){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z       <= '0;
      z_valid <= 1'b0;
    end else if (clr) begin
      z       <= '0;
      z_valid <= 1'b0;
    end else begin
      z_valid <= cvld[N_STAGES] & cemit[N_STAGES];
      if (cvld[N_STAGES] && cemit[N_STAGES]) z <= z_nxt;
    end
  end

endmodule
